// File: rtl/xb_pkg.sv
// Shared constants, state encoding and header/trailer word layout for the
// Xillybus read-FIFO arbiter.
package xb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_ABORT,
      ST_DROP
   } xb_state_e;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   localparam logic [7:0] TRL_MAGIC = 8'hDE;
   localparam logic [3:0] HDR_TAG   = 4'h0;
   localparam logic [3:0] TRL_TAG   = 4'hF;

   // Field positions inside a header/trailer word
   localparam int MAGIC_LSB = 24;
   localparam int ID_LSB    = 20;
   localparam int TAG_LSB   = 16;
   localparam int CNT_LSB   = 0;

   function automatic logic [31:0] mk_word(input logic [7:0]  magic,
                                           input logic [2:0]  id,
                                           input logic [3:0]  tag,
                                           input logic [15:0] cnt);
      logic [31:0] w;
      w = '0;
      w[MAGIC_LSB +: 8] = magic;
      w[ID_LSB    +: 4] = {1'b0, id};
      w[TAG_LSB   +: 4] = tag;
      w[CNT_LSB   +: 16] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic         found,
   output logic [2:0]   idx
);

   logic [7:0] req_pad;
   assign req_pad = 8'(req);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req_pad[3'((int'(ptr) + k) % N)]) begin
            found = 1'b1;
            idx   = 3'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/xb_rd_arbiter.sv
// Packet-granular round-robin arbiter feeding the Xillybus 32-bit read FIFO,
// with header/trailer framing and stall / host-close recovery.
module xb_rd_arbiter
   import xb_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic                 bus_clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [31:0]          fifo_din,
   output logic                 fifo_wr_en,
   input  logic                 fifo_full,
   output logic [2:0]           grant_id,
   output logic                 busy,
   output logic [15:0]          abort_cnt
);

   localparam logic [15:0] STALL_TO = 16'(STALL_TIMEOUT);

   xb_state_e   state, state_nxt;
   logic [2:0]  rr_ptr, rr_nxt, grant_nxt;
   logic [15:0] seq, seq_nxt, wc, wc_nxt, stall_cnt, stall_nxt, abort_nxt;
   logic [15:0] stall_inc, abort_inc;
   logic        ready_en;
   logic        pick_found;
   logic [2:0]  pick_idx;

   // Pad to 8 lanes so a 3-bit grant index always selects in range
   logic [7:0]   valid_pad, last_pad;
   logic [255:0] data_pad;
   logic         cur_valid, cur_last;
   logic [31:0]  cur_data;

   assign valid_pad = 8'(req_valid);
   assign last_pad  = 8'(req_last);
   assign data_pad  = 256'(req_data);
   assign cur_valid = valid_pad[grant_id];
   assign cur_last  = last_pad[grant_id];
   assign cur_data  = data_pad[{grant_id, 5'd0} +: 32];

   assign stall_inc = stall_cnt + 16'd1;
   assign abort_inc = (abort_cnt == 16'hFFFF) ? abort_cnt : abort_cnt + 16'd1;
   assign busy      = (state != ST_IDLE);

   rr_pick #(.N(N_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   for (genvar i = 0; i < N_REQ; i++) begin : g_ready
      assign req_ready[i] = ready_en && (grant_id == 3'(i));
   end

   always_comb begin
      state_nxt  = state;
      rr_nxt     = rr_ptr;
      grant_nxt  = grant_id;
      seq_nxt    = seq;
      wc_nxt     = wc;
      stall_nxt  = stall_cnt;
      abort_nxt  = abort_cnt;
      ready_en   = 1'b0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      case (state)
         ST_IDLE: begin
            if (enable && pick_found) begin
               grant_nxt = pick_idx;
               rr_nxt    = pick_idx;
               state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (!fifo_full) begin
               fifo_wr_en = 1'b1;
               fifo_din   = mk_word(HDR_MAGIC, grant_id, HDR_TAG, seq);
               seq_nxt    = seq + 16'd1;
               wc_nxt     = '0;
               stall_nxt  = '0;
               state_nxt  = ST_DATA;
            end
         end
         ST_DATA: begin
            ready_en = !fifo_full;
            if (cur_valid && !fifo_full) begin
               fifo_wr_en = 1'b1;
               fifo_din   = cur_data;
               wc_nxt     = (wc == 16'hFFFF) ? wc : wc + 16'd1;
               stall_nxt  = '0;
               if (cur_last) begin
                  state_nxt = ST_IDLE;
               end else if (!enable) begin
                  state_nxt = ST_DROP;
                  abort_nxt = abort_inc;
               end
            end else if (!enable) begin
               // Host closed mid-packet: no trailer, nobody is reading it
               state_nxt = ST_DROP;
               abort_nxt = abort_inc;
               stall_nxt = '0;
            end else if (stall_inc == STALL_TO) begin
               state_nxt = ST_ABORT;
               stall_nxt = '0;
            end else begin
               stall_nxt = stall_inc;
            end
         end
         ST_ABORT: begin
            if (!fifo_full) begin
               fifo_wr_en = 1'b1;
               fifo_din   = mk_word(TRL_MAGIC, grant_id, TRL_TAG, wc);
               abort_nxt  = abort_inc;
               stall_nxt  = '0;
               state_nxt  = ST_DROP;
            end
         end
         ST_DROP: begin
            ready_en = 1'b1;
            if (cur_valid) begin
               stall_nxt = '0;
               if (cur_last) state_nxt = ST_IDLE;
            end else if (stall_inc == STALL_TO) begin
               stall_nxt = '0;
               state_nxt = ST_IDLE;
            end else begin
               stall_nxt = stall_inc;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge bus_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= 3'(N_REQ - 1);
         grant_id  <= '0;
         seq       <= '0;
         wc        <= '0;
         stall_cnt <= '0;
         abort_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         grant_id  <= grant_nxt;
         seq       <= seq_nxt;
         wc        <= wc_nxt;
         stall_cnt <= stall_nxt;
         abort_cnt <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_xb_rd_arbiter.sv
// Self-checking bench for xb_rd_arbiter: directed framing/recovery scenarios
// followed by randomized traffic, all checked cycle by cycle against a model.
module tb_xb_rd_arbiter;

   localparam int N  = 4;
   localparam int TO = 1024;

   logic              bus_clk = 1'b0;
   logic              reset_n;
   logic              enable;
   logic [N-1:0]      req_valid, req_last, req_ready;
   logic [32*N-1:0]   req_data;
   logic [31:0]       fifo_din;
   logic              fifo_wr_en, fifo_full;
   logic [2:0]        grant_id;
   logic              busy;
   logic [15:0]       abort_cnt;

   always #5 bus_clk = ~bus_clk;

   xb_rd_arbiter #(.N_REQ(N), .STALL_TIMEOUT(TO)) dut (
      .bus_clk    (bus_clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .grant_id   (grant_id),
      .busy       (busy),
      .abort_cnt  (abort_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Requester side: per-requester word queues {last, data}
   logic [32:0] rq [N][$];
   int          mute [N];
   int          vprob = 100;
   logic [31:0] wlog [$];

   // Reference model: who owns the FIFO and what is owed next
   bit m_act, m_hdr, m_trl, m_drop;
   int m_own, m_rr, m_seq, m_wc, m_idle, m_abort;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_hdr = 0; m_trl = 0; m_drop = 0;
      m_own = 0; m_rr = N - 1; m_seq = 0; m_wc = 0; m_idle = 0; m_abort = 0;
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push_pkt(input int i, input int len);
      for (int k = 0; k < len; k++) rq[i].push_back({(k == len - 1), $urandom()});
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0 && mute[i] == 0 && $urandom_range(99) < vprob) begin
            req_valid[i]          = 1'b1;
            req_last[i]           = rq[i][0][32];
            req_data[i*32 +: 32]  = rq[i][0][31:0];
         end else begin
            req_valid[i]          = 1'b0;
            req_last[i]           = 1'b0;
            req_data[i*32 +: 32]  = '0;
         end
      end
   endtask

   task automatic cycle();
      logic [N-1:0] e_rdy, acc;
      logic         e_wr;
      logic [31:0]  e_din;
      bit n_act, n_hdr, n_trl, n_drop;
      int n_own, n_rr, n_seq, n_wc, n_idle, n_abort;
      bit picked;
      drive_reqs();
      @(negedge bus_clk);
      n_act = m_act; n_hdr = m_hdr; n_trl = m_trl; n_drop = m_drop;
      n_own = m_own; n_rr = m_rr; n_seq = m_seq; n_wc = m_wc;
      n_idle = m_idle; n_abort = m_abort;
      e_rdy = '0; e_wr = 1'b0; e_din = '0; picked = 0;
      if (!m_act) begin
         if (enable) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_rr + k) % N;
               if (!picked && req_valid[c]) begin
                  picked = 1; n_act = 1; n_hdr = 1; n_own = c; n_rr = c;
               end
            end
         end
      end else if (m_hdr) begin
         if (!fifo_full) begin
            e_wr = 1'b1;
            e_din = {8'hA5, 4'(m_own), 4'h0, 16'(m_seq)};
            n_seq = (m_seq + 1) % 65536; n_wc = 0; n_idle = 0; n_hdr = 0;
         end
      end else if (m_trl) begin
         if (!fifo_full) begin
            e_wr = 1'b1;
            e_din = {8'hDE, 4'(m_own), 4'hF, 16'(m_wc)};
            n_abort = (m_abort < 65535) ? m_abort + 1 : m_abort;
            n_trl = 0; n_drop = 1; n_idle = 0;
         end
      end else if (m_drop) begin
         e_rdy[m_own] = 1'b1;
         if (req_valid[m_own]) begin
            n_idle = 0;
            if (req_last[m_own]) begin n_act = 0; n_drop = 0; end
         end else begin
            n_idle = m_idle + 1;
            if (n_idle == TO) begin n_idle = 0; n_act = 0; n_drop = 0; end
         end
      end else begin
         e_rdy[m_own] = !fifo_full;
         if (req_valid[m_own] && !fifo_full) begin
            e_wr = 1'b1;
            e_din = req_data[m_own*32 +: 32];
            n_wc = (m_wc < 65535) ? m_wc + 1 : m_wc;
            n_idle = 0;
            if (req_last[m_own]) n_act = 0;
            else if (!enable) begin
               n_drop = 1; n_abort = (m_abort < 65535) ? m_abort + 1 : m_abort;
            end
         end else if (!enable) begin
            n_drop = 1; n_idle = 0;
            n_abort = (m_abort < 65535) ? m_abort + 1 : m_abort;
         end else begin
            n_idle = m_idle + 1;
            if (n_idle == TO) begin n_trl = 1; n_idle = 0; end
         end
      end
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      if (e_wr) chk("fifo_din", fifo_din, e_din);
      chk("grant_id", 32'(grant_id), m_own);
      chk("busy", 32'(busy), 32'(m_act));
      chk("abort_cnt", 32'(abort_cnt), m_abort);
      if (fifo_wr_en) wlog.push_back(fifo_din);
      acc = req_valid & req_ready;
      @(posedge bus_clk);
      m_act = n_act; m_hdr = n_hdr; m_trl = n_trl; m_drop = n_drop;
      m_own = n_own; m_rr = n_rr; m_seq = n_seq; m_wc = n_wc;
      m_idle = n_idle; m_abort = n_abort;
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         if (mute[i] > 0) mute[i]--;
      end
   endtask

   task automatic run_idle(input int max, input string nm);
      int k;
      k = 0;
      while ((m_act || pending()) && k < max) begin
         cycle();
         k++;
      end
      n_cmp++;
      if (k >= max) begin
         n_bad++;
         $display("FAIL %s: still busy after %0d cycles, expected drained", nm, k);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_fifo_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_fifo_din", fifo_din, 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_abort_cnt", 32'(abort_cnt), 0);
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         mute[i] = 0;
      end
      req_valid = '0; req_last = '0; req_data = '0;
      model_reset();
      @(negedge bus_clk);
      @(negedge bus_clk);
      reset_n = 1'b1;
      @(posedge bus_clk);
      #1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin
      enable = 1'b1; fifo_full = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      for (int i = 0; i < N; i++) mute[i] = 0;
      do_reset();

      // T1: 3-word packet from req0
      wlog.delete();
      rq[0].push_back({1'b0, 32'h11}); rq[0].push_back({1'b0, 32'h22});
      rq[0].push_back({1'b1, 32'h33});
      run_idle(50, "t1_drain");
      chk("t1_len", wlog.size(), 4);
      chk("t1_hdr", wlog[0], 32'hA5000000);
      chk("t1_w0", wlog[1], 32'h11);
      chk("t1_w2", wlog[3], 32'h33);
      chk("t1_grant", 32'(grant_id), 0);

      // T2: req1 and req2 together, single-word packets
      wlog.delete();
      rq[1].push_back({1'b1, 32'hAA}); rq[2].push_back({1'b1, 32'hBB});
      run_idle(50, "t2_drain");
      chk("t2_len", wlog.size(), 4);
      chk("t2_hdr1", wlog[0], 32'hA5100001);
      chk("t2_d1", wlog[1], 32'hAA);
      chk("t2_hdr2", wlog[2], 32'hA5200002);
      chk("t2_d2", wlog[3], 32'hBB);

      // T3: fifo_full held 5 cycles mid-packet
      wlog.delete();
      for (int k = 0; k < 4; k++) rq[0].push_back({(k == 3), 32'(32'h20 + k)});
      repeat (3) cycle();
      fifo_full = 1'b1;
      repeat (5) cycle();
      chk("t3_held", wlog.size(), 2);
      fifo_full = 1'b0;
      run_idle(50, "t3_drain");
      chk("t3_len", wlog.size(), 5);
      chk("t3_hdr", wlog[0], 32'hA5000003);
      chk("t3_w3", wlog[4], 32'h23);
      chk("t3_aborts", 32'(abort_cnt), 0);

      // T4: req3 stalls after 2 words -> trailer, rest discarded
      wlog.delete();
      for (int k = 0; k < 4; k++) rq[3].push_back({(k == 3), 32'(32'h31 + k)});
      repeat (4) cycle();
      mute[3] = 1040;
      repeat (1040) cycle();
      run_idle(100, "t4_drain");
      chk("t4_len", wlog.size(), 4);
      chk("t4_hdr", wlog[0], 32'hA5300004);
      chk("t4_w1", wlog[2], 32'h32);
      chk("t4_trl", wlog[3], 32'hDE3F0002);
      chk("t4_aborts", 32'(abort_cnt), 1);

      // T5: enable drops right after header
      wlog.delete();
      for (int k = 0; k < 3; k++) rq[1].push_back({(k == 2), 32'(32'h41 + k)});
      cycle();
      mute[1] = 5;
      cycle();
      enable = 1'b0;
      cycle();
      chk("t5_busy_drop", 32'(busy), 1);
      chk("t5_aborts", 32'(abort_cnt), 2);
      rq[2].push_back({1'b1, 32'h51});
      repeat (12) cycle();
      chk("t5_idle", 32'(busy), 0);
      chk("t5_q1_drained", rq[1].size(), 0);
      chk("t5_q2_waiting", rq[2].size(), 1);
      chk("t5_no_trl", wlog.size(), 1);
      chk("t5_hdr", wlog[0], 32'hA5100005);
      enable = 1'b1;
      run_idle(50, "t5_drain");
      chk("t5_grant", 32'(grant_id), 2);
      chk("t5_hdr2", wlog[1], 32'hA5200006);

      // T6: reset mid-DATA
      for (int k = 0; k < 3; k++) rq[0].push_back({(k == 2), 32'(32'h61 + k)});
      repeat (3) cycle();
      do_reset();
      wlog.delete();
      rq[2].push_back({1'b1, 32'h71});
      run_idle(50, "t6_drain");
      chk("t6_hdr", wlog[0], 32'hA5200000);
      chk("t6_d", wlog[1], 32'h71);

      // Randomized traffic with backpressure, host close and stalls
      vprob = 70;
      for (int t = 0; t < 4000; t++) begin
         for (int i = 0; i < N; i++)
            if (rq[i].size() == 0 && $urandom_range(9) == 0) push_pkt(i, 1 + int'($urandom_range(5)));
         fifo_full = ($urandom_range(99) < 20);
         if (t % 700 == 300) enable = 1'b0;
         if (t % 700 == 315) enable = 1'b1;
         if (t == 1200 || t == 2600) mute[$urandom_range(N - 1)] = 1100;
         cycle();
      end
      enable = 1'b1; fifo_full = 1'b0; vprob = 100;
      for (int i = 0; i < N; i++) mute[i] = 0;
      run_idle(3000, "rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
